// File: rtl/csa_cpa_seq.sv
// -----------------------------------------------------------------------------
// csa_cpa_seq
//   Sequential carry-propagate adder that resolves a carry-save pair into a
//   single binary value: out_res = in_sum + (in_carry << 1).
//   The add is done CHUNK bits per cycle so the full-width carry chain never
//   sits on one clock path. NCH = ceil((WID+2)/CHUNK) add cycles per result.
//
// Parameters
//   WID    width of the carry/sum vectors
//   CHUNK  bits resolved per cycle, 1..WID+2
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_vld    carry/sum pair valid
//   in_rdy    pair can be accepted (IDLE only, low while in reset)
//   in_carry  carry vector, bit i has weight 2^(i+1)
//   in_sum    sum vector, bit i has weight 2^i
//   out_vld   result valid (DONE only)
//   out_rdy   downstream accepts the result
//   out_res   exact WID+2 bit result
//   busy      high while in ADD or DONE
// -----------------------------------------------------------------------------
module csa_cpa_seq #(
  parameter int WID   = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WID-1:0]   in_carry,
  input  logic [WID-1:0]   in_sum,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WID+1:0]   out_res,
  output logic             busy
);

  localparam int RW  = WID + 2;
  localparam int NCH = (RW + CHUNK - 1) / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            cy_q;
  logic [RW-1:0]   a_q;
  logic [RW-1:0]   b_q;
  logic [RW-1:0]   res_q;
  logic [RW-1:0]   res_nxt;
  logic [CHUNK:0]  chunk_sum;

  // One chunk of the ripple: CHUNK-bit add with carry in, carry out on top.
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             ci);
    add_chunk = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Operands are shifted right by CHUNK every ADD cycle, so the current chunk
  // is always at the bottom and zeros shifting in provide the top padding.
  assign chunk_sum = add_chunk(a_q[CHUNK-1:0], b_q[CHUNK-1:0], cy_q);

  // Result bit i belongs to chunk i/CHUNK; only the active chunk is replaced.
  // Bits of a padded top chunk beyond RW are provably zero and are not kept.
  for (genvar i = 0; i < RW; i++) begin : g_res
    assign res_nxt[i] = (cnt_q == CW'(i / CHUNK)) ? chunk_sum[i % CHUNK] : res_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_vld) begin
            a_q     <= {2'b00, in_sum};
            b_q     <= {1'b0, in_carry, 1'b0};
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            state_q <= ADD;
          end
        end
        ADD: begin
          // ---- chunk add stage: one CHUNK slice resolved per cycle ----
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          cy_q  <= chunk_sum[CHUNK];
          res_q <= res_nxt;
          if (cnt_q == CW'(NCH - 1)) begin
            // Final carry out is always zero: 3*2^WID-3 fits in WID+2 bits.
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_rdy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_rdy is gated by rst_n so nothing is offered while reset is held.
  assign in_rdy  = (state_q == IDLE) && rst_n;
  assign out_vld = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign out_res = res_q;

endmodule

// File: tb/tb_csa_cpa_seq.sv
// -----------------------------------------------------------------------------
// tb_csa_cpa_seq
//   Bench for csa_cpa_seq with three instances (CHUNK = 1, 8, 34 at WID = 32).
//   Index 1 (CHUNK = 8) carries the handshake corner cases.
// -----------------------------------------------------------------------------
module tb_csa_cpa_seq;

  localparam int WID = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_vld   [3];
  logic             in_rdy   [3];
  logic [WID-1:0]   in_carry [3];
  logic [WID-1:0]   in_sum   [3];
  logic             out_vld  [3];
  logic             out_rdy  [3];
  logic [WID+1:0]   out_res  [3];
  logic             busy     [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    csa_cpa_seq #(
      .WID   (WID),
      .CHUNK (g == 0 ? 1 : (g == 1 ? 8 : 34))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (in_vld[g]),
      .in_rdy   (in_rdy[g]),
      .in_carry (in_carry[g]),
      .in_sum   (in_sum[g]),
      .out_vld  (out_vld[g]),
      .out_rdy  (out_rdy[g]),
      .out_res  (out_res[g]),
      .busy     (busy[g])
    );
  end

  typedef struct {
    logic [31:0] carry;
    logic [31:0] sum;
    logic [33:0] res;
  } vec_t;

  vec_t vec [10];

  function automatic int exp_lat(input int d);
    return (d == 0) ? 34 : ((d == 1) ? 5 : 1);
  endfunction

  function automatic logic [33:0] model(input logic [31:0] c, input logic [31:0] s);
    return {2'b00, s} + {1'b0, c, 1'b0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Raises in_vld and returns at #1 after the accepting edge; in_vld is left high.
  task automatic start_op(input int d, input logic [31:0] c, input logic [31:0] s,
                          output int acc_cyc);
    int   n;
    logic rdy;
    in_carry[d] = c;
    in_sum[d]   = s;
    in_vld[d]   = 1'b1;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = in_rdy[d];
      @(posedge clk);
      #1;
      n++;
    end
    acc_cyc = cyc;
    if (!rdy) timeout($sformatf("accept%0d", d));
  endtask

  // Counts rising edges from the accept edge until out_vld is seen.
  task automatic wait_res(input int d, output logic [33:0] res, output int lat);
    lat = 0;
    while (!out_vld[d] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_vld[d]) timeout($sformatf("result%0d", d));
    res = out_res[d];
  endtask

  task automatic run_op(input int d, input logic [31:0] c, input logic [31:0] s,
                        input bit hold, output logic [33:0] res, output int lat,
                        output int acc_cyc);
    start_op(d, c, s, acc_cyc);
    if (!hold) in_vld[d] = 1'b0;
    wait_res(d, res, lat);
  endtask

  task automatic sweep(input int d);
    logic [31:0] c, s;
    logic [33:0] res;
    int lat, acc;
    for (int k = 0; k < 1000; k++) begin
      c = $urandom();
      s = $urandom();
      run_op(d, c, s, 1'b0, res, lat, acc);
      check($sformatf("sweep%0d_res", d), 64'(res), 64'(model(c, s)));
      check($sformatf("sweep%0d_lat", d), 64'(lat), 64'(exp_lat(d)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] res;
    logic [33:0] hold_res;
    int          lat;
    int          acc;
    int          acc_prev;
    logic        seen;
    logic [31:0] bc [4];
    logic [31:0] bs [4];

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_vld[d]   = 1'b0;
      in_carry[d] = '0;
      in_sum[d]   = '0;
      out_rdy[d]  = 1'b1;
    end

    vec[0] = '{32'h0000_0001, 32'h0000_0001, 34'h0_0000_0003};
    vec[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 34'h2_FFFF_FFFD};
    vec[2] = '{32'h0000_0000, 32'h0000_0000, 34'h0_0000_0000};
    vec[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 34'h0_FFFF_FFFF};
    vec[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 34'h1_FFFF_FFFE};
    vec[5] = '{32'h8000_0000, 32'h0000_0000, 34'h1_0000_0000};
    vec[6] = '{32'h0000_0080, 32'h0000_0000, 34'h0_0000_0100};
    vec[7] = '{32'h0000_007F, 32'h0000_0002, 34'h0_0000_0100};
    vec[8] = '{32'h1234_5678, 32'h1111_1111, 34'h0_3579_BE01};
    vec[9] = '{32'hAAAA_AAAA, 32'h5555_5555, 34'h1_AAAA_AAA9};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_out_vld%0d", d), 64'(out_vld[d]), 64'd0);
      check($sformatf("rst_busy%0d", d),    64'(busy[d]),    64'd0);
      check($sformatf("rst_out_res%0d", d), 64'(out_res[d]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("rst_in_rdy%0d", d), 64'(in_rdy[d]), 64'd1);

    // Directed table on every chunk size
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 10; i++) begin
        run_op(d, vec[i].carry, vec[i].sum, 1'b0, res, lat, acc);
        check($sformatf("vec%0d_%0d_res", d, i), 64'(res), 64'(vec[i].res));
        check($sformatf("vec%0d_%0d_lat", d, i), 64'(lat), 64'(exp_lat(d)));
      end
    end

    // Backpressure in DONE with noisy inputs
    out_rdy[1] = 1'b0;
    run_op(1, 32'h0F0F_0F0F, 32'h1234_5678, 1'b0, hold_res, lat, acc);
    check("bp_res", 64'(hold_res), 64'h0_3052_7496);
    for (int k = 0; k < 10; k++) begin
      in_vld[1]   = k[0];
      in_carry[1] = $urandom();
      in_sum[1]   = $urandom();
      @(posedge clk);
      #1;
      check("bp_out_vld", 64'(out_vld[1]), 64'd1);
      check("bp_out_res", 64'(out_res[1]), 64'h0_3052_7496);
      check("bp_in_rdy",  64'(in_rdy[1]),  64'd0);
    end
    in_vld[1]  = 1'b0;
    out_rdy[1] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_vld", 64'(out_vld[1]), 64'd0);
    check("bp_release_rdy", 64'(in_rdy[1]),  64'd1);
    @(posedge clk);
    #1;
    check("bp_no_accept", 64'(busy[1]), 64'd0);

    // Reset two cycles into ADD
    start_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
    in_vld[1] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_vld", 64'(out_vld[1]), 64'd0);
    check("midrst_busy",    64'(busy[1]),    64'd0);
    check("midrst_out_res", 64'(out_res[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_rdy", 64'(in_rdy[1]), 64'd1);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_vld[1]) seen = 1'b1;
    end
    check("midrst_no_result", 64'(seen), 64'd0);

    // Back-to-back with in_vld held high
    bc[0] = 32'h0000_0003; bs[0] = 32'h0000_0005;
    bc[1] = 32'hDEAD_BEEF; bs[1] = 32'hCAFE_F00D;
    bc[2] = 32'h7FFF_FFFF; bs[2] = 32'h0000_0001;
    bc[3] = 32'h0001_0000; bs[3] = 32'hFFFF_0000;
    acc_prev = 0;
    for (int i = 0; i < 4; i++) begin
      run_op(1, bc[i], bs[i], 1'b1, res, lat, acc);
      check($sformatf("b2b_res%0d", i), 64'(res), 64'(model(bc[i], bs[i])));
      if (i > 0) check($sformatf("b2b_gap%0d", i), 64'(acc - acc_prev), 64'd7);
      acc_prev = acc;
    end
    in_vld[1] = 1'b0;
    @(posedge clk);
    #1;

    // Random sweep across all chunk sizes in parallel
    fork
      sweep(0);
      sweep(1);
      sweep(2);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
